l1_ahb_mtx_arb_rr_burst: RTL and testbench

//  Round-robin, burst-aware output arbiter for one L1 AHB matrix output stage, shared by 3 input ports.

---
 rtl/l1_ahb_mtx_arb_rr_burst_if.sv | 27 ++
 rtl/l1_ahb_mtx_arb_rr_burst.sv | 110 +++++++++++
 tb/tb_l1_ahb_mtx_arb_rr_burst.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/l1_ahb_mtx_arb_rr_burst_if.sv
// Request/bus view and grant outputs of one L1 AHB matrix output-stage arbiter.
// master: drives requests and the output transfer; slave: the arbiter itself.
interface l1_ahb_mtx_arb_rr_burst_if;
  logic       req_port0;
  logic       req_port1;
  logic       req_port2;
  logic       HREADYM;
  logic       HSELM;
  logic [1:0] HTRANSM;
  logic [2:0] HBURSTM;
  logic       HMASTLOCKM;
  logic [1:0] addr_in_port;
  logic       no_port;
  logic       burst_active;

  modport master (
    output req_port0, req_port1, req_port2,
    output HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
    input  addr_in_port, no_port, burst_active
  );

  modport slave (
    input  req_port0, req_port1, req_port2,
    input  HREADYM, HSELM, HTRANSM, HBURSTM, HMASTLOCKM,
    output addr_in_port, no_port, burst_active
  );
endinterface

// File: rtl/l1_ahb_mtx_arb_rr_burst.sv
// Round-robin, burst/lock-holding arbiter for one 3-port output stage; 1-cycle grant latency, frozen while HREADYM=0.
// Optional ARB_INCR_HOLD_EN: undefined-length INCR bursts hold the grant for INCR_HOLD_MAX beats.
module l1_ahb_mtx_arb_rr_burst #(
  parameter int unsigned RESET_LAST    = 2,
  parameter int unsigned INCR_HOLD_MAX = 8
) (
  input  logic                       HCLK,
  input  logic                       HRESETn,
  l1_ahb_mtx_arb_rr_burst_if.slave   bus
);

  localparam logic [1:0] TR_IDLE   = 2'b00;
  localparam logic [1:0] TR_BUSY   = 2'b01;
  localparam logic [1:0] TR_NONSEQ = 2'b10;
  localparam logic [1:0] TR_SEQ    = 2'b11;

`ifdef ARB_INCR_HOLD_EN
  localparam logic [3:0] INCR_LOAD = 4'(INCR_HOLD_MAX - 1);
`else
  // INCR behaves like SINGLE; the hold length has no effect here.
  localparam logic [3:0] INCR_LOAD = 4'd0 & 4'(INCR_HOLD_MAX);
`endif

  logic [1:0] addr_q;
  logic       no_port_q;
  logic [1:0] last_grant;
  logic [3:0] beat_cnt;

  logic [3:0] cnt_nxt;
  logic       hold;
  logic       xfer_active;
  logic [3:0] cand;
  logic [1:0] p1, p2, p3;
  logic       win_vld;
  logic [1:0] win;

  function automatic logic [1:0] next_port(input logic [1:0] p);
    return (p >= 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  assign xfer_active = bus.HSELM && (bus.HTRANSM != TR_IDLE);

  always_comb begin
    cnt_nxt = 4'd0;
    if (xfer_active) begin
      case (bus.HTRANSM)
        TR_NONSEQ: begin
          case (bus.HBURSTM)
            3'b000:         cnt_nxt = 4'd0;
            3'b001:         cnt_nxt = INCR_LOAD;
            3'b010, 3'b011: cnt_nxt = 4'd3;
            3'b100, 3'b101: cnt_nxt = 4'd7;
            default:        cnt_nxt = 4'd15;
          endcase
        end
        TR_SEQ:  cnt_nxt = (beat_cnt != 4'd0) ? beat_cnt - 4'd1 : 4'd0;
        TR_BUSY: cnt_nxt = beat_cnt;
        default: cnt_nxt = 4'd0;
      endcase
    end
  end

  assign hold = bus.HMASTLOCKM || (cnt_nxt != 4'd0);

  // The port currently on the bus stays eligible while its transfer is still running.
  always_comb begin
    cand    = 4'b0000;
    cand[0] = bus.req_port0 || (addr_q == 2'd0 && xfer_active);
    cand[1] = bus.req_port1 || (addr_q == 2'd1 && xfer_active);
    cand[2] = bus.req_port2 || (addr_q == 2'd2 && xfer_active);
  end

  assign p1 = next_port(last_grant);
  assign p2 = next_port(p1);
  assign p3 = next_port(p2);

  always_comb begin
    win_vld = 1'b1;
    win     = addr_q;
    if (cand[p1])      win = p1;
    else if (cand[p2]) win = p2;
    else if (cand[p3]) win = p3;
    else               win_vld = 1'b0;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      addr_q     <= 2'd0;
      no_port_q  <= 1'b1;
      last_grant <= 2'(RESET_LAST);
      beat_cnt   <= 4'd0;
    end else if (bus.HREADYM) begin
      beat_cnt <= cnt_nxt;
      if (hold) begin
        no_port_q <= 1'b0;
      end else if (win_vld) begin
        addr_q     <= win;
        no_port_q  <= 1'b0;
        last_grant <= win;
      end else begin
        no_port_q <= !bus.HSELM;
      end
    end
  end

  assign bus.addr_in_port = addr_q;
  assign bus.no_port      = no_port_q;
  assign bus.burst_active = (beat_cnt != 4'd0);

endmodule

// File: tb/tb_l1_ahb_mtx_arb_rr_burst.sv
// Randomized and directed bench for the round-robin burst arbiter against a behavioural model.
module tb_l1_ahb_mtx_arb_rr_burst;

  localparam int RESET_LAST    = 2;
  localparam int INCR_HOLD_MAX = 8;
`ifdef ARB_INCR_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  bit   chk_en = 1'b0;

  l1_ahb_mtx_arb_rr_burst_if bus();

  l1_ahb_mtx_arb_rr_burst #(
    .RESET_LAST   (RESET_LAST),
    .INCR_HOLD_MAX(INCR_HOLD_MAX)
  ) dut (
    .HCLK   (clk),
    .HRESETn(rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  // Behavioural model: remaining beats as an integer, grant chosen by scanning ports after the last winner.
  int m_addr, m_nop, m_last, m_rem;

  function automatic int burst_len(input logic [2:0] b);
    case (b)
      3'd0:       return 1;
      3'd1:       return HOLD_EN ? INCR_HOLD_MAX : 1;
      3'd2, 3'd3: return 4;
      3'd4, 3'd5: return 8;
      default:    return 16;
    endcase
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int  nrem, win, p;
    bit  found, active;
    logic [2:0] req;
    if (!rst_n) begin
      m_addr <= 0; m_nop <= 1; m_last <= RESET_LAST; m_rem <= 0;
    end else if (bus.HREADYM) begin
      active = bus.HSELM && bus.HTRANSM != 2'b00;
      if (!active)                  nrem = 0;
      else if (bus.HTRANSM == 2'b10) nrem = burst_len(bus.HBURSTM) - 1;
      else if (bus.HTRANSM == 2'b11) nrem = (m_rem > 0) ? m_rem - 1 : 0;
      else                          nrem = m_rem;
      req = {bus.req_port2, bus.req_port1, bus.req_port0};
      if (bus.HMASTLOCKM || nrem != 0) begin
        m_nop <= 0;
      end else begin
        found = 0; win = 0;
        for (int k = 1; k <= 3; k++) begin
          p = (m_last + k) % 3;
          if (!found && (req[p] || (p == m_addr && active))) begin
            found = 1; win = p;
          end
        end
        if (found) begin
          m_addr <= win; m_nop <= 0; m_last <= win;
        end else begin
          m_nop <= bus.HSELM ? 0 : 1;
        end
      end
      m_rem <= nrem;
    end
  end

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("addr_in_port", int'(bus.addr_in_port), m_addr);
      check("no_port", int'(bus.no_port), m_nop);
      check("burst_active", int'(bus.burst_active), (m_rem != 0) ? 1 : 0);
    end
  end

  task automatic lit_addr(input string nm, input int exp);
    check(nm, int'(bus.addr_in_port), exp);
    check({nm, "_model"}, m_addr, exp);
  endtask

  task automatic lit_ba(input string nm, input int exp);
    check(nm, int'(bus.burst_active), exp);
    check({nm, "_model"}, (m_rem != 0) ? 1 : 0, exp);
  endtask

  task automatic drv(input logic [2:0] req, input logic rdy, input logic sel,
                     input logic [1:0] tr, input logic [2:0] bu, input logic lk);
    bus.req_port0  = req[0];
    bus.req_port1  = req[1];
    bus.req_port2  = req[2];
    bus.HREADYM    = rdy;
    bus.HSELM      = sel;
    bus.HTRANSM    = tr;
    bus.HBURSTM    = bu;
    bus.HMASTLOCKM = lk;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    drv(3'b000, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int fair_exp [6] = '{0, 1, 2, 0, 1, 2};
  int ba_exp3  [3] = '{1, 1, 0};
  int addr_exp3[3] = '{1, 1, 0};

  initial begin
    drv(3'b000, 1'b0, 1'b0, 2'b00, 3'b000, 1'b0);
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    lit_addr("reset_addr", 0);
    check("reset_no_port", int'(bus.no_port), 1);
    lit_ba("reset_burst_active", 0);

    drv(3'b001, 1'b1, 1'b0, 2'b00, 3'b000, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    lit_addr("release_addr", 0);
    check("release_no_port", int'(bus.no_port), 0);

    // Fairness with all ports requesting.
    do_reset();
    drv(3'b111, 1'b1, 1'b1, 2'b10, 3'b000, 1'b0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      lit_addr($sformatf("fair_%0d", i), fair_exp[i]);
    end

    // INCR4 burst from port1 while port0 waits.
    drv(3'b010, 1'b1, 1'b1, 2'b00, 3'b000, 1'b0);
    @(negedge clk);
    lit_addr("incr4_pre", 1);
    drv(3'b001, 1'b1, 1'b1, 2'b10, 3'b011, 1'b0);
    @(negedge clk);
    lit_addr("incr4_b1", 1);
    lit_ba("incr4_b1_ba", 1);
    drv(3'b001, 1'b1, 1'b1, 2'b11, 3'b011, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      lit_addr($sformatf("incr4_seq%0d", i), addr_exp3[i]);
      lit_ba($sformatf("incr4_seq%0d_ba", i), ba_exp3[i]);
    end

    // WRAP8 with wait states, BUSY beats and early IDLE termination.
    drv(3'b010, 1'b1, 1'b1, 2'b10, 3'b100, 1'b0);
    @(negedge clk);
    lit_addr("wrap8_b1", 0);
    drv(3'b010, 1'b0, 1'b1, 2'b11, 3'b100, 1'b0);
    repeat (3) begin
      @(negedge clk);
      lit_addr("wrap8_wait", 0);
      lit_ba("wrap8_wait_ba", 1);
    end
    drv(3'b010, 1'b1, 1'b1, 2'b11, 3'b100, 1'b0);
    repeat (2) @(negedge clk);
    drv(3'b010, 1'b1, 1'b1, 2'b01, 3'b100, 1'b0);
    repeat (2) @(negedge clk);
    lit_addr("wrap8_busy", 0);
    drv(3'b010, 1'b1, 1'b1, 2'b11, 3'b100, 1'b0);
    repeat (2) @(negedge clk);
    lit_addr("wrap8_b5", 0);
    lit_ba("wrap8_b5_ba", 1);
    drv(3'b010, 1'b1, 1'b1, 2'b00, 3'b100, 1'b0);
    @(negedge clk);
    lit_addr("wrap8_idle", 1);
    lit_ba("wrap8_idle_ba", 0);

    // Locked sequence on port2.
    drv(3'b100, 1'b1, 1'b1, 2'b00, 3'b000, 1'b0);
    @(negedge clk);
    lit_addr("lock_pre", 2);
    drv(3'b001, 1'b1, 1'b1, 2'b10, 3'b000, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      lit_addr($sformatf("lock_%0d", i), 2);
    end
    drv(3'b001, 1'b1, 1'b1, 2'b00, 3'b000, 1'b0);
    @(negedge clk);
    lit_addr("lock_drop", 0);

    // Undefined-length INCR with port1 pending.
    drv(3'b010, 1'b1, 1'b1, 2'b10, 3'b001, 1'b0);
    @(negedge clk);
    lit_addr("incr_b1", HOLD_EN ? 0 : 1);
    drv(3'b010, 1'b1, 1'b1, 2'b11, 3'b001, 1'b0);
    for (int i = 2; i <= INCR_HOLD_MAX; i++) begin
      @(negedge clk);
      lit_addr($sformatf("incr_b%0d", i), (HOLD_EN && i < INCR_HOLD_MAX) ? 0 : 1);
    end

    // Asynchronous reset in the middle of an INCR16.
    drv(3'b000, 1'b1, 1'b1, 2'b10, 3'b111, 1'b0);
    @(negedge clk);
    lit_ba("incr16_ba", 1);
    #2 rst_n = 1'b0;
    #1;
    lit_addr("arst_addr", 0);
    check("arst_no_port", int'(bus.no_port), 1);
    lit_ba("arst_ba", 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      int t;
      logic [1:0] tr;
      t = $urandom_range(0, 9);
      tr = (t < 2) ? 2'b00 : (t < 3) ? 2'b01 : (t < 6) ? 2'b10 : 2'b11;
      drv(3'($urandom_range(0, 7)), ($urandom_range(0, 9) < 8), ($urandom_range(0, 19) < 17),
          tr, 3'($urandom_range(0, 7)), ($urandom_range(0, 9) == 0));
      if ($urandom_range(0, 999) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
      end else begin
        @(negedge clk);
      end
    end

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
